// File: rtl/urv_mult_serial_pkg.sv
// Shared constants and small decode helpers for the serial RV32M multiplier.
package urv_mult_serial_pkg;

  // funct3 encodings of the RV32M multiply group
  localparam logic [2:0] FUNC_MUL    = 3'b000;
  localparam logic [2:0] FUNC_MULH   = 3'b001;
  localparam logic [2:0] FUNC_MULHSU = 3'b010;
  localparam logic [2:0] FUNC_MULHU  = 3'b011;

  localparam int STATE_W = 3;

  // rs1 is treated as signed for MUL, MULH and MULHSU
  function automatic logic op_a_signed(input logic [2:0] fun);
    return (fun == FUNC_MUL) || (fun == FUNC_MULH) || (fun == FUNC_MULHSU);
  endfunction

  // rs2 is treated as signed for MUL and MULH only
  function automatic logic op_b_signed(input logic [2:0] fun);
    return (fun == FUNC_MUL) || (fun == FUNC_MULH);
  endfunction

endpackage

// File: rtl/urv_mult_serial_if.sv
// Decode/execute bus between the pipeline and the serial multiplier.
//
// Handshake: a request is d_valid_i && d_is_multiply_i. The unit accepts it
// only from IDLE and only when x_kill_i is low. x_stall_req_o stays high while
// a request is pending or in flight and drops in the one cycle x_rd_o carries
// the finished result (DONE). x_stall_i keeps the unit in DONE with x_rd_o
// frozen; x_kill_i aborts an in-flight operation but never a finished one.
interface urv_mult_serial_if;
  import urv_mult_serial_pkg::*;

  logic                 x_stall_i;
  logic                 x_kill_i;
  logic                 x_stall_req_o;
  logic                 d_valid_i;
  logic                 d_is_multiply_i;
  logic [31:0]          d_rs1_i;
  logic [31:0]          d_rs2_i;
  logic [2:0]           d_fun_i;
  logic [31:0]          x_rd_o;
  logic [STATE_W-1:0]   dbg_state;

  modport master (
    output x_stall_i, x_kill_i, d_valid_i, d_is_multiply_i,
           d_rs1_i, d_rs2_i, d_fun_i,
    input  x_stall_req_o, x_rd_o, dbg_state
  );

  modport slave (
    input  x_stall_i, x_kill_i, d_valid_i, d_is_multiply_i,
           d_rs1_i, d_rs2_i, d_fun_i,
    output x_stall_req_o, x_rd_o, dbg_state
  );
endinterface

// File: rtl/urv_cond_negate.sv
// Width-parameterised conditional two's-complement: q = neg ? -d : d.
module urv_cond_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] d,
  input  logic         neg,
  output logic [W-1:0] q
);

  // 0x80..0 maps onto itself, which callers read as the unsigned magnitude
  assign q = neg ? (~d + {{(W-1){1'b0}}, 1'b1}) : d;

endmodule

// File: rtl/urv_mult_serial.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes, multiplied unsigned over 32 cycles and
// the 64-bit product is negated back when exactly one operand was negative.
module urv_mult_serial (
  input  logic              clk_i,
  input  logic              rst_i,
  urv_mult_serial_if.slave  bus
);
  import urv_mult_serial_pkg::*;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_ABS  = 3'd1;
  localparam logic [STATE_W-1:0] ST_ITER = 3'd2;
  localparam logic [STATE_W-1:0] ST_NEG  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;

  logic [31:0] a;
  logic [63:0] p;
  logic [4:0]  cnt;
  logic        a_sgn;
  logic        b_sgn;
  logic        hi_sel;
  logic        neg;
  logic [31:0] x_rd;

  logic        start;
  logic        stall_req;
  logic        abs_en;
  logic        iter_en;
  logic        neg_en;

  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [63:0] p_signed;
  logic [32:0] sum;

  assign start = bus.d_valid_i && bus.d_is_multiply_i && !bus.x_kill_i && (state == ST_IDLE);

  // During the load the raw rs2 sits in p[31:0]; ABS turns it into |rs2|
  urv_cond_negate #(.W(32)) u_abs_a (.d(a),        .neg(a_sgn), .q(a_abs));
  urv_cond_negate #(.W(32)) u_abs_b (.d(p[31:0]),  .neg(b_sgn), .q(b_abs));
  urv_cond_negate #(.W(64)) u_neg_p (.d(p),        .neg(neg),   .q(p_signed));

  // Single accumulator adder; its carry becomes the new p[63]
  assign sum = {1'b0, p[63:32]} + (p[0] ? {1'b0, a} : 33'd0);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: kill aborts any in-flight step but not a finished result
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_ABS;
      ST_ABS:  state_nxt = bus.x_kill_i ? ST_IDLE : ST_ITER;
      ST_ITER: begin
        if (bus.x_kill_i)      state_nxt = ST_IDLE;
        else if (cnt == 5'd31) state_nxt = ST_NEG;
      end
      ST_NEG:  state_nxt = bus.x_kill_i ? ST_IDLE : ST_DONE;
      ST_DONE: state_nxt = bus.x_stall_i ? ST_DONE : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output/control decode from the current state
  always_comb begin
    stall_req = bus.d_valid_i && bus.d_is_multiply_i && (state != ST_DONE);
    abs_en    = (state == ST_ABS)  && !bus.x_kill_i;
    iter_en   = (state == ST_ITER) && !bus.x_kill_i;
    neg_en    = (state == ST_NEG)  && !bus.x_kill_i;
  end

  // Datapath: operand capture, magnitude step, shift-add and result select
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a      <= 32'h0;
      p      <= 64'h0;
      cnt    <= 5'd0;
      a_sgn  <= 1'b0;
      b_sgn  <= 1'b0;
      hi_sel <= 1'b0;
      neg    <= 1'b0;
      x_rd   <= 32'h0;
    end else if (start) begin
      a      <= bus.d_rs1_i;
      p      <= {32'h0, bus.d_rs2_i};
      hi_sel <= (bus.d_fun_i != FUNC_MUL);
      a_sgn  <= op_a_signed(bus.d_fun_i) && bus.d_rs1_i[31];
      b_sgn  <= op_b_signed(bus.d_fun_i) && bus.d_rs2_i[31];
    end else if (abs_en) begin
      a   <= a_abs;
      p   <= {32'h0, b_abs};
      neg <= a_sgn ^ b_sgn;
      cnt <= 5'd0;
    end else if (iter_en) begin
      p   <= {sum, p[31:1]};
      cnt <= cnt + 5'd1;
    end else if (neg_en) begin
      x_rd <= hi_sel ? p_signed[63:32] : p_signed[31:0];
    end
  end

  assign bus.x_stall_req_o = stall_req;
  assign bus.x_rd_o        = x_rd;
  assign bus.dbg_state     = state;

endmodule
